// File: rtl/key_repeater.sv
// Typematic key repeater: each key emits one pulse on press, then repeat pulses
// after an initial delay while it stays held. The two channels are independent.

module key_repeater_ch #(
   parameter int DELAY_CYCLES  = 20,
   parameter int REPEAT_CYCLES = 8,
   parameter int CNT_W         = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic key,
   output logic pulse,
   output logic rep
);
   typedef enum logic [1:0] {ARM, IDLE, DELAY, REPEAT} state_t;

   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             pulse_n;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ARM;
         cnt   <= '0;
         pulse <= 1'b0;
         rep   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         pulse <= pulse_n;
         rep   <= (state_n == REPEAT);
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pulse_n = 1'b0;
      case (state)
         // A key already down at reset must be seen released before it counts.
         ARM: if (!key) state_n = IDLE;
         IDLE: if (key) begin
            pulse_n = 1'b1;
            cnt_n   = '0;
            state_n = DELAY;
         end
         DELAY: begin
            if (!key) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == DLY_LAST) begin
               pulse_n = 1'b1;
               cnt_n   = '0;
               state_n = REPEAT;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         REPEAT: begin
            if (!key) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == REP_LAST) begin
               pulse_n = 1'b1;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         default: state_n = ARM;
      endcase
   end
endmodule

module key_repeater #(
   parameter int DELAY_CYCLES  = 20,
   parameter int REPEAT_CYCLES = 8,
   parameter int CNT_W         = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic I0,
   input  logic I1,
   output logic P0,
   output logic P1,
   output logic R0,
   output logic R1
);
   localparam int NUM_LANES = 2;

   logic [NUM_LANES-1:0] key, pulse, rep;

   assign key = {I1, I0};
   assign P0  = pulse[0];
   assign P1  = pulse[1];
   assign R0  = rep[0];
   assign R1  = rep[1];

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_ch
      key_repeater_ch #(
         .DELAY_CYCLES (DELAY_CYCLES),
         .REPEAT_CYCLES(REPEAT_CYCLES),
         .CNT_W        (CNT_W)
      ) u_ch (
         .clock(clock),
         .reset(reset),
         .key  (key[g]),
         .pulse(pulse[g]),
         .rep  (rep[g])
      );
   end
endmodule

// File: tb/tb_key_repeater.sv
// Bench for key_repeater: a normal (4/2) and a fast (1/1) instance share stimulus
// and are compared every cycle against a hold-length reference model.

module tb_key_repeater;
   logic clock = 1'b0, reset = 1'b1, I0 = 1'b0, I1 = 1'b0;
   logic P0, P1, R0, R1;
   logic fP0, fP1, fR0, fR1;
   int   checks = 0, passed = 0;

   // model state: index 0/1 = normal ch0/ch1, 2/3 = fast ch0/ch1
   bit       blk [4] = '{1, 1, 1, 1};
   int       hk  [4] = '{0, 0, 0, 0};
   bit [3:0] exp_n, exp_f;   // {P1,P0,R1,R0}

   always #5 clock = ~clock;

   key_repeater #(.DELAY_CYCLES(4), .REPEAT_CYCLES(2), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .I0(I0), .I1(I1),
      .P0(P0), .P1(P1), .R0(R0), .R1(R1));

   key_repeater #(.DELAY_CYCLES(1), .REPEAT_CYCLES(1), .CNT_W(4)) dut_f (
      .clock(clock), .reset(reset), .I0(I0), .I1(I1),
      .P0(fP0), .P1(fP1), .R0(fR0), .R1(fR1));

   // k = number of consecutive edges the key has been sampled high since armed.
   // Pulses at k=1, k=1+d, then every r edges; repeat flag once k>=1+d.
   function automatic void mstep(input bit rst, input bit i, input int d, input int r,
                                 inout bit b, inout int k, output bit p, output bit rr);
      p = 0; rr = 0;
      if (rst) begin b = 1; k = 0; end
      else if (b) begin if (!i) b = 0; k = 0; end
      else if (i) begin
         k++;
         p  = (k == 1) || (k == 1 + d) || (k > 1 + d && (k - 1 - d) % r == 0);
         rr = (k >= 1 + d);
      end else k = 0;
   endfunction

   task automatic tick(input bit rst, input bit i0, input bit i1);
      bit p0, p1, r0, r1;
      reset = rst; I0 = i0; I1 = i1;
      @(posedge clock);
      mstep(rst, i0, 4, 2, blk[0], hk[0], p0, r0);
      mstep(rst, i1, 4, 2, blk[1], hk[1], p1, r1);
      exp_n = {p1, p0, r1, r0};
      mstep(rst, i0, 1, 1, blk[2], hk[2], p0, r0);
      mstep(rst, i1, 1, 1, blk[3], hk[3], p1, r1);
      exp_f = {p1, p0, r1, r0};
      #1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         tick(1, c[0], 1);
         checks++;
         if ({P1, P0, R1, R0, fP1, fP0, fR1, fR0} !== 8'h00)
            $display("FAIL reset cyc%0d got=%b exp=00000000", c, {P1, P0, R1, R0, fP1, fP0, fR1, fR0});
         else passed++;
      end
   endtask

   task automatic test_tap();
      int npulse = 0;
      bit seq [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
      tick(1, 0, 0);
      for (int c = 0; c < 8; c++) begin
         tick(0, seq[c], 0);
         npulse += P0;
         checks++;
         if ({P1, P0, R1, R0} !== exp_n) $display("FAIL tap cyc%0d got=%b exp=%b", c, {P1, P0, R1, R0}, exp_n);
         else passed++;
      end
      checks++;
      if (npulse !== 1) $display("FAIL tap_count got=%0d exp=1", npulse);
      else passed++;
   endtask

   task automatic test_hold();
      bit [15:0] pm = '0, rm = '0;
      tick(1, 0, 0);
      for (int e = 1; e <= 9; e++) tick(0, 0, 0);
      for (int e = 10; e <= 25; e++) begin
         tick(0, e < 22, 0);
         pm[e - 10] = P0; rm[e - 10] = R0;
         checks++;
         if ({P1, P0, R1, R0} !== exp_n) $display("FAIL hold edge%0d got=%b exp=%b", e, {P1, P0, R1, R0}, exp_n);
         else passed++;
      end
      // pulses after edges 10,14,16,18,20; R after 14..21
      checks++;
      if (pm !== 16'b0000_0101_0101_0001) $display("FAIL hold_pulses got=%b exp=%b", pm, 16'b0000_0101_0101_0001);
      else passed++;
      checks++;
      if (rm !== 16'b0000_1111_1111_0000) $display("FAIL hold_rep got=%b exp=%b", rm, 16'b0000_1111_1111_0000);
      else passed++;
   endtask

   task automatic test_reset_held();
      tick(0, 0, 1);
      tick(1, 0, 1);
      tick(1, 0, 1);
      for (int c = 0; c < 13; c++) begin
         tick(0, 0, !(c == 10));
         checks++;
         if ({P1, P0, R1, R0, fP1, fP0, fR1, fR0} !== {exp_n, exp_f})
            $display("FAIL reset_held cyc%0d got=%b exp=%b", c, {P1, P0, R1, R0, fP1, fP0, fR1, fR0}, {exp_n, exp_f});
         else passed++;
         if (c == 11) begin
            checks++;
            if (P1 !== 1'b1) $display("FAIL reset_held_repress got=%b exp=1", P1);
            else passed++;
         end
      end
   endtask

   task automatic test_mid_reset();
      tick(1, 0, 0);
      tick(0, 0, 0);
      for (int c = 0; c < 8; c++) tick(0, 1, 0);
      checks++;
      if (R0 !== 1'b1) $display("FAIL mid_reset_in_repeat got=%b exp=1", R0);
      else passed++;
      tick(1, 1, 0);
      checks++;
      if ({P0, R0} !== 2'b00) $display("FAIL mid_reset_clear got=%b exp=00", {P0, R0});
      else passed++;
      for (int c = 0; c < 10; c++) begin
         tick(0, c < 7 || c > 7, 0);
         checks++;
         if ({P1, P0, R1, R0, fP1, fP0, fR1, fR0} !== {exp_n, exp_f})
            $display("FAIL mid_reset cyc%0d got=%b exp=%b", c, {P1, P0, R1, R0, fP1, fP0, fR1, fR0}, {exp_n, exp_f});
         else passed++;
      end
   endtask

   task automatic test_independent();
      tick(1, 0, 0);
      for (int e = 1; e <= 16; e++) begin
         tick(0, e >= 5, e >= 5 && e < 8);
         checks++;
         if ({P1, P0, R1, R0} !== exp_n) $display("FAIL indep edge%0d got=%b exp=%b", e, {P1, P0, R1, R0}, exp_n);
         else passed++;
         if (e == 5 || e == 9) begin
            checks++;
            if ({P1, P0} !== ((e == 5) ? 2'b11 : 2'b01)) $display("FAIL indep_pulse edge%0d got=%b", e, {P1, P0});
            else passed++;
         end
      end
   endtask

   task automatic test_fast();
      bit [7:0] pm = '0;
      tick(1, 0, 0);
      tick(0, 0, 0);
      for (int c = 0; c < 8; c++) begin
         tick(0, c < 5, 0);
         pm[c] = fP0;
         checks++;
         if ({fP1, fP0, fR1, fR0} !== exp_f) $display("FAIL fast cyc%0d got=%b exp=%b", c, {fP1, fP0, fR1, fR0}, exp_f);
         else passed++;
      end
      checks++;
      if (pm !== 8'b0001_1111) $display("FAIL fast_run got=%b exp=00011111", pm);
      else passed++;
   endtask

   task automatic test_random();
      bit i0 = 0, i1 = 0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 5) == 0) i0 = ~i0;
         if ($urandom_range(0, 6) == 0) i1 = ~i1;
         tick($urandom_range(0, 60) == 0, i0, i1);
         checks++;
         if ({P1, P0, R1, R0, fP1, fP0, fR1, fR0} !== {exp_n, exp_f})
            $display("FAIL random cyc%0d got=%b exp=%b", c, {P1, P0, R1, R0, fP1, fP0, fR1, fR0}, {exp_n, exp_f});
         else passed++;
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_tap();
      test_hold();
      test_reset_held();
      test_mid_reset();
      test_independent();
      test_fast();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
